// File: rtl/axi_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : axi_write_scheduler
//  Description : Round-robin scheduler that shares one AXI write slave port
//                among NM masters. One master owns the port for a whole
//                transaction (AW, W burst, B). Only the handshake signals are
//                routed here; payload muxes outside use 'grant' as the select.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    ACLK, ARESETn         clock, asynchronous active-low reset
//    m_awvalid/m_awlen     per-master address requests (AWLEN i at [i*LENW +: LENW])
//    m_wvalid/m_wlast      per-master write data handshake
//    m_bready              per-master response ready
//    m_awready/m_wready/m_bvalid   handshakes returned to the masters
//    s_awvalid/s_awready, s_wvalid/s_wready, s_bvalid/s_bready   slave side
//    grant                 registered one-hot owner, 0 when idle
//    state                 0 IDLE, 1 ADDR, 2 DATA, 3 RESP
//    len_err               one-cycle pulse on burst length mismatch
// ============================================================================
module axi_write_scheduler #(
  parameter int NM   = 2,
  parameter int LENW = 4
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [NM-1:0]      m_awvalid,
  input  logic [NM*LENW-1:0] m_awlen,
  input  logic [NM-1:0]      m_wvalid,
  input  logic [NM-1:0]      m_wlast,
  input  logic [NM-1:0]      m_bready,
  output logic [NM-1:0]      m_awready,
  output logic [NM-1:0]      m_wready,
  output logic [NM-1:0]      m_bvalid,
  output logic               s_awvalid,
  input  logic               s_awready,
  output logic               s_wvalid,
  input  logic               s_wready,
  input  logic               s_bvalid,
  output logic               s_bready,
  output logic [NM-1:0]      grant,
  output logic [1:0]         state,
  output logic               len_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [NM-1:0] c_prio_rst = {{(NM-1){1'b0}}, 1'b1};

  state_t          r_state, w_state_nxt;
  logic [NM-1:0]   r_grant, w_grant_nxt;
  logic [NM-1:0]   r_prio, w_prio_nxt;
  logic [LENW-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [LENW-1:0] r_len_lat, w_len_lat_nxt;
  logic            r_len_err, w_len_err_nxt;

  logic [NM-1:0]   w_win;
  logic            w_own_awvalid, w_own_wvalid, w_own_wlast, w_own_bready;
  logic [LENW-1:0] w_own_awlen;

  // Owner-side inputs: grant is one-hot (or zero), so AND-OR selects the owner.
  assign w_own_awvalid = |(m_awvalid & r_grant);
  assign w_own_wvalid  = |(m_wvalid  & r_grant);
  assign w_own_wlast   = |(m_wlast   & r_grant);
  assign w_own_bready  = |(m_bready  & r_grant);

  always_comb begin
    w_own_awlen = '0;
    for (int i = 0; i < NM; i++) begin
      if (r_grant[i]) w_own_awlen = w_own_awlen | m_awlen[i*LENW +: LENW];
    end
  end

  // Round-robin search: first requester at or after the priority pointer.
  always_comb begin
    int  prio_idx;
    int  idx;
    logic found;
    w_win    = '0;
    found    = 1'b0;
    prio_idx = 0;
    idx      = 0;
    for (int i = 0; i < NM; i++) begin
      if (r_prio[i]) prio_idx = i;
    end
    for (int k = 0; k < NM; k++) begin
      idx = prio_idx + k;
      if (idx >= NM) idx = idx - NM;
      if (!found && m_awvalid[idx]) begin
        w_win[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_prio     <= c_prio_rst;
      r_beat_cnt <= '0;
      r_len_lat  <= '0;
      r_len_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_prio     <= w_prio_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_len_lat  <= w_len_lat_nxt;
      r_len_err  <= w_len_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_prio_nxt     = r_prio;
    w_beat_cnt_nxt = r_beat_cnt;
    w_len_lat_nxt  = r_len_lat;
    w_len_err_nxt  = 1'b0;
    m_awready      = '0;
    m_wready       = '0;
    m_bvalid       = '0;
    s_awvalid      = 1'b0;
    s_wvalid       = 1'b0;
    s_bready       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|m_awvalid) begin
          w_grant_nxt = w_win;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        // Grant is held even if the owner withdraws AWVALID.
        s_awvalid = w_own_awvalid;
        m_awready = r_grant & {NM{s_awready}};
        if (w_own_awvalid && s_awready) begin
          w_len_lat_nxt  = w_own_awlen;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = S_DATA;
        end
      end
      S_DATA: begin
        s_wvalid = w_own_wvalid;
        m_wready = r_grant & {NM{s_wready}};
        if (w_own_wvalid && s_wready) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          // WLAST always ends the burst; a mismatch against AWLEN is only flagged.
          if (w_own_wlast) begin
            w_state_nxt   = S_RESP;
            w_len_err_nxt = (r_beat_cnt != r_len_lat);
          end else begin
            w_len_err_nxt = (r_beat_cnt == r_len_lat);
          end
        end
      end
      S_RESP: begin
        m_bvalid = r_grant & {NM{s_bvalid}};
        s_bready = w_own_bready;
        if (s_bvalid && w_own_bready) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          // The just-served master becomes lowest priority.
          w_prio_nxt  = {r_grant[NM-2:0], r_grant[NM-1]};
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign grant   = r_grant;
  assign state   = r_state;
  assign len_err = r_len_err;

endmodule
`default_nettype wire
